// File: rtl/loader_pkg.sv
// Purpose: framing-word constants and FSM state type shared by the program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package loader_pkg;

  localparam logic [23:0] START_WORD    = 24'hFF0000;
  localparam logic [23:0] STOP_RST_WORD = 24'hFFFF00;
  localparam logic [23:0] STOP_RUN_WORD = 24'hFFF000;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

endpackage

// File: rtl/word_assembler.sv
// Purpose: packs UART bytes b0,b1,b2 into {b2,b1,b0}; drops a stale partial word after an idle timeout.
// Latency: word/word_valid are combinational in the cycle the third byte is strobed.
// Backpressure: none; every rx_valid byte is consumed.
module word_assembler #(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [23:0] word,
  output logic        word_valid
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    idx;
  logic [15:0]   partial;
  logic [TW-1:0] idle_cnt;

  // The third byte completes the word in the same cycle it arrives, so the
  // top level can register its effect on the very next edge.
  assign word_valid = rx_valid && (idx == 2'd2);
  assign word       = {rx_byte, partial};

  // Byte capture, index advance and idle timeout; a fresh byte always wins over expiry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx      <= 2'd0;
      partial  <= 16'h0000;
      idle_cnt <= '0;
    end else if (rx_valid) begin
      idle_cnt <= '0;
      case (idx)
        2'd0: begin
          partial[7:0] <= rx_byte;
          idx          <= 2'd1;
        end
        2'd1: begin
          partial[15:8] <= rx_byte;
          idx           <= 2'd2;
        end
        default: idx <= 2'd0;
      endcase
    end else if (idx != 2'd0) begin
      if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        idx      <= 2'd0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end else begin
      idle_cnt <= '0;
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Purpose: loads instruction words framed by START/STOP words into imem, holding the CPU meanwhile.
// Latency: the byte completing a word in cycle N produces its write/state/hold/restart effect in N+1.
// Backpressure: none; words arriving when memory is full are dropped and flagged in overflow.
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [23:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              cpu_rst,
  output logic              loading,
  output logic [ADDR_W:0]   load_count,
  output logic              overflow
);

  state_t        state, next_state;
  logic [23:0]   word;
  logic          word_valid;
  logic [ADDR_W:0] cnt;
  logic          is_start, is_stop_rst, is_stop_run;

  word_assembler #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .word      (word),
    .word_valid(word_valid)
  );

  assign is_start    = (word == START_WORD);
  assign is_stop_rst = (word == STOP_RST_WORD);
  assign is_stop_run = (word == STOP_RUN_WORD);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state decode from completed framing words.
  always_comb begin
    next_state = state;
    if (word_valid) begin
      case (state)
        IDLE:    if (is_start) next_state = LOAD;
        LOAD:    if (is_stop_rst || is_stop_run) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // State-derived outputs: the CPU is held exactly while loading.
  always_comb begin
    loading  = (state == LOAD);
    cpu_hold = (state == LOAD);
  end

  // Address counter, write port, restart pulse and overflow flag.
  // The counter's top bit marks "memory full", so it saturates at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 24'h000000;
      cpu_rst    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      cpu_rst <= 1'b0;
      if (word_valid) begin
        if (is_start) begin
          cnt      <= '0;
          overflow <= 1'b0;
        end else if (state == LOAD) begin
          if (is_stop_rst) begin
            cpu_rst <= 1'b1;
          end else if (!is_stop_run) begin
            if (!cnt[ADDR_W]) begin
              imem_we    <= 1'b1;
              imem_addr  <= cnt[ADDR_W-1:0];
              imem_wdata <= word;
              cnt        <= cnt + 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign load_count = cnt;

endmodule

// File: tb/tb_uart_program_loader.sv
// Purpose: scoreboard bench driving a wide (ADDR_W=8) and a tiny (ADDR_W=2) loader with one byte stream.
// Latency: expected events are queued when a word completes; the monitor compares on each DUT event.
// Backpressure: none; the bench spaces rx_valid at least two cycles apart.
module tb_uart_program_loader;

  localparam int TO = 40;
  localparam logic [23:0] W_START    = 24'hFF0000;
  localparam logic [23:0] W_STOP_RST = 24'hFFFF00;
  localparam logic [23:0] W_STOP_RUN = 24'hFFF000;
  localparam logic [1:0] K_WRITE = 2'd0, K_RISE = 2'd1, K_FALL = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  addr;
    logic [23:0] data;
    logic        rst_pulse;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] rx_byte;
  logic rx_valid;

  logic we_a, hold_a, crst_a, loading_a, ov_a;
  logic [7:0] addr_a;
  logic [23:0] wdata_a;
  logic [8:0] lc_a;
  logic we_b, hold_b, crst_b, loading_b, ov_b;
  logic [1:0] addr_b;
  logic [23:0] wdata_b;
  logic [2:0] lc_b;

  int total = 0;
  int bad = 0;
  bit mon_on = 1'b0;
  bit prev_hold [2];

  ev_t q0[$];
  ev_t q1[$];

  // Reference model state per instance
  int  m_cnt  [2];
  bit  m_load [2];
  bit  m_ov   [2];
  int  depth  [2];
  logic [7:0] part[$];

  uart_program_loader #(.ADDR_W(8), .TIMEOUT_CYCLES(TO)) u_a (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a), .cpu_hold(hold_a),
    .cpu_rst(crst_a), .loading(loading_a), .load_count(lc_a), .overflow(ov_a)
  );

  uart_program_loader #(.ADDR_W(2), .TIMEOUT_CYCLES(TO)) u_b (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b), .cpu_hold(hold_b),
    .cpu_rst(crst_b), .loading(loading_b), .load_count(lc_b), .overflow(ov_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s u%0d got=%0h want=%0h t=%0t", name, i, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic ev_t pop_ev(input int i);
    if (i == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic push_ev(input int i, input logic [1:0] k, input int a, input logic [23:0] d, input logic p);
    ev_t e;
    e.kind = k; e.addr = 8'(a); e.data = d; e.rst_pulse = p;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Compare one instance's visible events against its queue
  task automatic mon_inst(input int i, input logic we, input int addr, input logic [23:0] wd,
                          input logic hold, input logic crst, input int lc);
    ev_t e;
    bit rise, fall;
    rise = hold && !prev_hold[i];
    fall = !hold && prev_hold[i];
    if (we || rise || fall) begin
      if (qsize(i) == 0) begin
        check("unexpected_event", i, {29'd0, we, rise, fall}, 32'd0);
      end else begin
        e = pop_ev(i);
        if (we) begin
          check("write_kind", i, 32'(K_WRITE), 32'(e.kind));
          check("write_addr", i, addr, 32'(e.addr));
          check("write_data", i, 32'(wd), 32'(e.data));
          check("write_count", i, lc, 32'(e.addr) + 1);
        end else if (rise) begin
          check("hold_rise_kind", i, 32'(K_RISE), 32'(e.kind));
        end else begin
          check("hold_fall_kind", i, 32'(K_FALL), 32'(e.kind));
          check("cpu_rst_pulse", i, 32'(crst), 32'(e.rst_pulse));
        end
      end
    end
    if (crst && !fall) check("stray_cpu_rst", i, 32'(crst), 32'd0);
    prev_hold[i] = hold;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon_inst(0, we_a, 32'(addr_a), wdata_a, hold_a, crst_a, 32'(lc_a));
      mon_inst(1, we_b, 32'(addr_b), wdata_b, hold_b, crst_b, 32'(lc_b));
    end
  end

  // Reference model: effect of one complete word on each instance
  task automatic apply_word(input logic [23:0] w);
    for (int i = 0; i < 2; i++) begin
      if (!m_load[i]) begin
        if (w == W_START) begin
          m_load[i] = 1'b1; m_cnt[i] = 0; m_ov[i] = 1'b0;
          push_ev(i, K_RISE, 0, 24'h0, 1'b0);
        end
      end else if (w == W_START) begin
        m_cnt[i] = 0; m_ov[i] = 1'b0;
      end else if (w == W_STOP_RST) begin
        m_load[i] = 1'b0;
        push_ev(i, K_FALL, 0, 24'h0, 1'b1);
      end else if (w == W_STOP_RUN) begin
        m_load[i] = 1'b0;
        push_ev(i, K_FALL, 0, 24'h0, 1'b0);
      end else if (m_cnt[i] < depth[i]) begin
        push_ev(i, K_WRITE, m_cnt[i], w, 1'b0);
        m_cnt[i]++;
      end else begin
        m_ov[i] = 1'b1;
      end
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
    if (n + 1 >= TO) part.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    part.push_back(b);
    if (part.size() == 3) begin
      apply_word({part[2], part[1], part[0]});
      part.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [23:0] w);
    send_byte(w[7:0]);   gap($urandom_range(0, 6));
    send_byte(w[15:8]);  gap($urandom_range(0, 6));
    send_byte(w[23:16]); gap($urandom_range(0, 3));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (m_load[i]) push_ev(i, K_FALL, 0, 24'h0, 1'b0);
      m_load[i] = 1'b0; m_cnt[i] = 0; m_ov[i] = 1'b0;
    end
    part.delete();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic check_state();
    @(negedge clk);
    check("load_count", 0, 32'(lc_a), m_cnt[0]);
    check("load_count", 1, 32'(lc_b), m_cnt[1]);
    check("overflow", 0, 32'(ov_a), 32'(m_ov[0]));
    check("overflow", 1, 32'(ov_b), 32'(m_ov[1]));
    check("cpu_hold", 0, 32'(hold_a), 32'(m_load[0]));
    check("cpu_hold", 1, 32'(hold_b), 32'(m_load[1]));
    check("loading", 0, 32'(loading_a), 32'(m_load[0]));
    check("loading", 1, 32'(loading_b), 32'(m_load[1]));
  endtask

  task automatic check_reset_vals();
    @(negedge clk);
    check("rst_outputs", 0, {we_a, addr_a, wdata_a[15:0], hold_a, crst_a, loading_a, ov_a}, 32'd0);
    check("rst_wdata_hi", 0, 32'(wdata_a[23:16]) | 32'(lc_a), 32'd0);
    check("rst_outputs", 1, {we_b, addr_b, wdata_b[23:0], hold_b, crst_b, loading_b, ov_b}, 32'd0);
    check("rst_count", 1, 32'(lc_b), 32'd0);
  endtask

  // Watchdog: the stimulus is time-bounded, but guard against anything unexpected
  initial begin
    repeat (80000) @(posedge clk);
    bad++;
    $display("FAIL watchdog cycle budget expired");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int r;
    depth[0] = 256; depth[1] = 4;
    for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_load[i] = 0; m_ov[i] = 0; prev_hold[i] = 0; end
    rst = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    check_reset_vals();
    mon_on = 1'b1;

    // Words in IDLE are discarded
    send_word(24'h800110);
    send_word(24'hB01000);
    check_state();

    // Load of three words ended with STOP_RST
    send_word(W_START); send_word(24'h800110); send_word(24'hB01000); send_word(24'hF00002);
    check_state();
    send_word(W_STOP_RST);
    check_state();

    // Same load ended with STOP_RUN
    send_word(W_START); send_word(24'h800110); send_word(24'hB01000); send_word(24'hF00002);
    send_word(W_STOP_RUN);
    check_state();

    // Partial word timeout
    send_word(W_START);
    send_byte(8'h10); send_byte(8'h01);
    gap(TO + 10);
    send_byte(8'h00); send_byte(8'h10); send_byte(8'hB0);
    check_state();
    send_word(W_STOP_RUN);

    // Overflow on the small instance, cleared by a second START
    send_word(W_START);
    for (int k = 0; k < 5; k++) send_word(24'h000100 + 24'(k));
    check_state();
    send_word(W_START);
    check_state();
    send_word(W_STOP_RUN);

    // Reset mid-load, then stray bytes are ignored
    send_word(W_START); send_word(24'h123456); send_byte(8'hAA);
    do_reset();
    check_reset_vals();
    send_word(24'h654321);
    check_state();

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 12)      send_word(W_START);
      else if (r < 17) send_word(W_STOP_RST);
      else if (r < 22) send_word(W_STOP_RUN);
      else if (r < 24) begin do_reset(); check_reset_vals(); end
      else if (r < 28) begin
        send_byte(8'($urandom));
        if ($urandom_range(0, 1) == 1) send_byte(8'($urandom));
        gap(TO + 10);
      end else send_word(24'($urandom));
      if (n % 10 == 9) check_state();
    end
    send_word(W_STOP_RUN);
    check_state();

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 0, q0.size(), 32'd0);
    check("queue_drained", 1, q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
